// File: rtl/mux_nx1_stream_if.sv
// Stream-side bundle for mux_nx1_stream: packed channel inputs, select/mode,
// request handshake and the registered output beat.
// Optional field out_par exists only when MUX_NX1_PARITY_EN is defined.
interface mux_nx1_stream_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N)
);
  logic [N*WIDTH-1:0] in;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out;
  logic [SEL_W-1:0]   out_ch;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_NX1_PARITY_EN
  logic               out_par;
`endif

  // Producer / consumer side (testbench or surrounding logic).
  modport master (
    output in, sel, mode, in_valid, out_ready,
    input  in_ready, out, out_ch, out_err, out_valid
`ifdef MUX_NX1_PARITY_EN
    , input out_par
`endif
  );

  // Mux side.
  modport slave (
    input  in, sel, mode, in_valid, out_ready,
    output in_ready, out, out_ch, out_err, out_valid
`ifdef MUX_NX1_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-to-1 stream multiplexer with a single registered output beat.
// Manual mode picks the channel from sel (out-of-range selects produce an
// error beat with zero data); auto mode scans channels round-robin.
// Optional feature macro: MUX_NX1_PARITY_EN adds out_par, the XOR-reduction
// of the captured data (0 on error beats).
module mux_nx1_stream #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  mux_nx1_stream_if.slave    bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;
`ifdef MUX_NX1_PARITY_EN
  logic             out_par_q, out_par_d;
`endif

  logic             accept;
  logic [SEL_W-1:0] ch;
  logic             illegal;
  logic [WIDTH-1:0] ch_data;

  // The output slot is free when empty or being drained this cycle; reset
  // blocks new requests so a request in a reset cycle is dropped.
  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Resolve the channel for this cycle and steer its data.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    ch_data = '0;
    ch      = bus.mode ? scan_ptr_q : bus.sel;
    // scan_ptr never exceeds N-1, so only manual selects can be illegal.
    illegal = (32'(ch) >= N);
    for (int k = 0; k < N; k++) begin
      if (ch == SEL_W'(k)) ch_data = bus.in[k*WIDTH +: WIDTH];
    end
  end

  // Next-state: load a new beat on accept, drop it on consume, advance scan.
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    scan_ptr_d  = scan_ptr_q;
`ifdef MUX_NX1_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (accept) begin
      // ch_data is already zero for an illegal select.
      out_d       = ch_data;
      out_ch_d    = ch;
      out_err_d   = illegal;
      out_valid_d = 1'b1;
`ifdef MUX_NX1_PARITY_EN
      out_par_d   = ^ch_data;
`endif
      if (bus.mode) begin
        scan_ptr_d = (scan_ptr_q == SEL_W'(N-1)) ? '0 : scan_ptr_q + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that also discards a pending beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_ptr_q  <= '0;
`ifdef MUX_NX1_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      scan_ptr_q  <= scan_ptr_d;
`ifdef MUX_NX1_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
`ifdef MUX_NX1_PARITY_EN
  assign bus.out_par   = out_par_q;
`endif

endmodule

// File: doc/mux_nx1_stream.md
MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 Parameter: N, default 8, number of input channels; legal range 2..64.
REQ-002 Parameter: WIDTH, default 8, bits per channel; legal range 1..64.
REQ-003 Parameter: SEL_W, default $clog2(N), width of select and channel-index fields; not overridden by users.
REQ-004 Ports: clk  input  1  sole clock, all state changes on rising edge.
REQ-005 Ports: rst  input  1  reset, synchronous and active-high.
REQ-006 Ports: in  input  N*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Ports: sel  input  SEL_W  channel select in manual mode.
REQ-008 Ports: mode  input  1  0 = manual (sel), 1 = auto round-robin scan.
REQ-009 Ports: in_valid  input  1  a selection request is presented.
REQ-010 Ports: in_ready  output  1  block can accept a request this cycle.
REQ-011 Ports: out  output  WIDTH  registered selected data.
REQ-012 Ports: out_ch  output  SEL_W  channel index that produced out.
REQ-013 Ports: out_err  output  1  out beat came from an illegal select (sel >= N).
REQ-014 Ports: out_valid  output  1  out/out_ch/out_err hold a beat.
REQ-015 Ports: out_ready  input  1  downstream consumes the beat.

Function
REQ-016 Accept = in_valid && in_ready; in_ready = !rst && (!out_valid || out_ready), combinational.
REQ-017 On accept, the output register loads at the same edge; latency request-to-out_valid is exactly one cycle.
REQ-018 Channel used on accept: manual mode sel; auto mode internal scan_ptr.
REQ-019 Manual mode, sel < N: out = in channel sel, out_ch = sel, out_err = 0.
REQ-020 Manual mode, sel >= N (N not a power of two): out = 0, out_ch = sel, out_err = 1; beat still delivered.
REQ-021 Auto mode: scan_ptr increments by 1 on each accept, wrapping from N-1 to 0; out_err always 0.
REQ-022 scan_ptr holds its value in manual mode and while no accept occurs; switching mode does not reset it.
REQ-023 out_valid sets on accept; clears on out_ready when no simultaneous accept; remains 1 on simultaneous consume and accept (new beat replaces old, no bubble).
REQ-024 While out_valid && !out_ready, out, out_ch, out_err are stable; in and sel changes do not affect them.
REQ-025 Data sampled is in at the accept edge; later in changes never alter a captured beat.

Reset
REQ-026 While rst is high at a clock edge: out = 0, out_ch = 0, out_err = 0, out_valid = 0, scan_ptr = 0.
REQ-027 rst dominates: a request presented in a reset cycle is dropped, in_ready = 0 during rst, and a pending output beat is discarded.
REQ-028 First accept after reset in auto mode selects channel 0.

Configuration
REQ-029 Macro MUX_NX1_PARITY_EN defined: extra output out_par (1 bit) = XOR-reduction of the captured channel data, registered with out; reset 0; 0 for error beats.
REQ-030 Macro MUX_NX1_PARITY_EN undefined: no out_par port; all other behaviour identical.

Verification
REQ-031 Manual: N=8, WIDTH=8, in channel3=8'hA5, sel=3, in_valid=1, out_ready=1 -> next cycle out=8'hA5, out_ch=3, out_valid=1, out_err=0.
REQ-032 Auto wrap: N=5, mode=1, in_valid held 7 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,4,0,1.
REQ-033 Illegal select: N=5, sel=6, one request -> out=0, out_ch=6, out_err=1 for one beat.
REQ-034 Backpressure: out_ready=0 after a first beat -> in_ready=0, out stable across 5 cycles while in changes; raising out_ready with in_valid=1 -> next beat loads on the same edge, out_valid stays 1.
REQ-035 Reset mid-operation: auto mode at scan_ptr=3 with out_valid=1, assert rst one cycle -> all outputs 0, out_valid=0; next accept gives out_ch=0.
REQ-036 Parity build: MUX_NX1_PARITY_EN defined, selected data 8'b0000_0111 -> out_par=1; 8'h0F -> out_par=0.
